ae350_reset_sequencer: RTL and testbench

Power-on and warm-reset sequencer feeding the AE350 SoC top-level reset inputs (POR_RSTN, DDR3_RSTN, HW_RSTN). It sits between the board reset button and PLL lock on one side and the SoC on the other. It orders reset release as PLL lock, then POR, then DDR3 controller, then CPU/bus hardware reset. It retries DDR3 initialisation on timeout and supports a software/watchdog warm reset of the hardware domain only.

---
 rtl/ae350_reset_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_ae350_reset_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ae350_reset_sequencer.sv
// ae350_reset_sequencer
// Orders reset release for the AE350 SoC: PLL lock, then POR, then the DDR3
// controller, then CPU/bus hardware reset. DDR3 calibration is retried on
// timeout, and a level-sensitive warm reset re-holds only the hardware domain.
//
// Ports:
//   CLK         free-running board clock
//   RSTN        async active-low reset (release synchronised through 2 flops)
//   PLL_LOCK    async PLL lock, 2-flop synchronised
//   DDR3_INIT   async DDR3 calibration-done, 2-flop synchronised
//   SW_RST_REQ  synchronous warm-reset request (level)
//   POR_RSTN    power-on reset to SoC, active low
//   DDR3_RSTN   DDR3 controller reset, active low
//   HW_RSTN     SoC hardware reset, active low
//   SEQ_DONE    high only while running
//   INIT_FAIL   high once DDR3 retries are exhausted
//   RETRY_CNT   DDR3 retries consumed
module ae350_reset_sequencer #(
  parameter int unsigned POR_CYCLES   = 1024,
  parameter int unsigned DDR_PULSE    = 64,
  parameter int unsigned INIT_TIMEOUT = 1048576,
  parameter int unsigned HW_CYCLES    = 256,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 24
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       PLL_LOCK,
  input  logic       DDR3_INIT,
  input  logic       SW_RST_REQ,
  output logic       POR_RSTN,
  output logic       DDR3_RSTN,
  output logic       HW_RSTN,
  output logic       SEQ_DONE,
  output logic       INIT_FAIL,
  output logic [3:0] RETRY_CNT
);

  localparam logic [CNT_W-1:0] PorLast   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] PulseLast = CNT_W'(DDR_PULSE - 1);
  localparam logic [CNT_W-1:0] InitLast  = CNT_W'(INIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HwLast    = CNT_W'(HW_CYCLES - 1);
  localparam logic [3:0]       MaxRetry  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    StWaitLock,
    StPorHold,
    StDdrWait,
    StDdrPulse,
    StHwHold,
    StRun,
    StFail
  } state_e;

  // Reset: asserts asynchronously, releases two clocks after RSTN rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [1:0] lock_sync_q;
  logic [1:0] init_sync_q;
  logic       lock;
  logic       init;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= 2'b00;
      init_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], PLL_LOCK};
      init_sync_q <= {init_sync_q[0], DDR3_INIT};
    end
  end

  assign lock = lock_sync_q[1];
  assign init = init_sync_q[1];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             por_d, ddr_d, hw_d, done_d, fail_d;

  // State register; outputs are registered copies of the next-state decode so
  // each output changes on the same edge as the state it belongs to.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StWaitLock;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      POR_RSTN  <= 1'b0;
      DDR3_RSTN <= 1'b0;
      HW_RSTN   <= 1'b0;
      SEQ_DONE  <= 1'b0;
      INIT_FAIL <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      POR_RSTN  <= por_d;
      DDR3_RSTN <= ddr_d;
      HW_RSTN   <= hw_d;
      SEQ_DONE  <= done_d;
      INIT_FAIL <= fail_d;
    end
  end

  assign RETRY_CNT = retry_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    // Lock loss outranks every other transition; FAIL only leaves via RSTN.
    if (!lock && state_q != StWaitLock && state_q != StFail) begin
      state_d = StWaitLock;
      cnt_d   = '0;
      retry_d = 4'd0;
    end else begin
      unique case (state_q)
        StWaitLock: begin
          if (lock) begin
            state_d = StPorHold;
            cnt_d   = '0;
          end
        end
        StPorHold: begin
          if (cnt_q == PorLast) begin
            state_d = StDdrWait;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDdrWait: begin
          if (init) begin
            state_d = StHwHold;
            cnt_d   = '0;
          end else if (cnt_q == InitLast) begin
            if (retry_q < MaxRetry) begin
              retry_d = retry_q + 4'd1;
              state_d = StDdrPulse;
              cnt_d   = '0;
            end else begin
              state_d = StFail;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDdrPulse: begin
          if (cnt_q == PulseLast) begin
            state_d = StDdrWait;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StHwHold: begin
          // A pending warm request keeps restarting the hold.
          if (SW_RST_REQ) begin
            cnt_d = '0;
          end else if (cnt_q == HwLast) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (SW_RST_REQ) begin
            state_d = StHwHold;
            cnt_d   = '0;
          end
        end
        StFail: begin
          state_d = StFail;
        end
        default: begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    por_d  = 1'b0;
    ddr_d  = 1'b0;
    hw_d   = 1'b0;
    done_d = 1'b0;
    fail_d = 1'b0;
    unique case (state_d)
      StWaitLock, StPorHold: ;
      StDdrWait, StHwHold: begin
        por_d = 1'b1;
        ddr_d = 1'b1;
      end
      StDdrPulse: por_d = 1'b1;
      StRun: begin
        por_d  = 1'b1;
        ddr_d  = 1'b1;
        hw_d   = 1'b1;
        done_d = 1'b1;
      end
      StFail: begin
        por_d  = 1'b1;
        fail_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ae350_reset_sequencer.sv
// Testbench for ae350_reset_sequencer: directed latency checks plus
// randomised episodes compared cycle by cycle with a phase/countdown model.
module tb_ae350_reset_sequencer;

  localparam int unsigned POR_CYCLES   = 8;
  localparam int unsigned DDR_PULSE    = 4;
  localparam int unsigned INIT_TIMEOUT = 16;
  localparam int unsigned HW_CYCLES    = 4;
  localparam int unsigned MAX_RETRY    = 2;

  logic       CLK = 1'b0;
  logic       RSTN, PLL_LOCK, DDR3_INIT, SW_RST_REQ;
  logic       POR_RSTN, DDR3_RSTN, HW_RSTN, SEQ_DONE, INIT_FAIL;
  logic [3:0] RETRY_CNT;

  ae350_reset_sequencer #(
    .POR_CYCLES  (POR_CYCLES),
    .DDR_PULSE   (DDR_PULSE),
    .INIT_TIMEOUT(INIT_TIMEOUT),
    .HW_CYCLES   (HW_CYCLES),
    .MAX_RETRY   (MAX_RETRY),
    .CNT_W       (24)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .PLL_LOCK  (PLL_LOCK),
    .DDR3_INIT (DDR3_INIT),
    .SW_RST_REQ(SW_RST_REQ),
    .POR_RSTN  (POR_RSTN),
    .DDR3_RSTN (DDR3_RSTN),
    .HW_RSTN   (HW_RSTN),
    .SEQ_DONE  (SEQ_DONE),
    .INIT_FAIL (INIT_FAIL),
    .RETRY_CNT (RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: named phase plus cycles left in it, inputs delayed by
  // two-entry shift arrays, internal reset released two edges after RSTN.
  string    phase = "wait";
  int       left = 0;
  int       retries = 0;
  bit       rst_low = 1'b1;
  int       rst_hold = 0;
  bit [1:0] lock_q = 2'b00;
  bit [1:0] init_q = 2'b00;

  function automatic logic [8:0] model_outs();
    logic por, ddr, hw, done, fail;
    por  = (phase == "ddr") || (phase == "pulse") || (phase == "hw") ||
           (phase == "run") || (phase == "fail");
    ddr  = (phase == "ddr") || (phase == "hw") || (phase == "run");
    hw   = (phase == "run");
    done = (phase == "run");
    fail = (phase == "fail");
    return {por, ddr, hw, done, fail, 4'(retries)};
  endfunction

  task automatic model_step();
    bit lk, in;
    if (rst_low) return;
    if (rst_hold > 0) begin
      rst_hold--;
      return;
    end
    lk = lock_q[1];
    in = init_q[1];
    lock_q = {lock_q[0], PLL_LOCK};
    init_q = {init_q[0], DDR3_INIT};
    if (!lk && phase != "wait" && phase != "fail") begin
      phase   = "wait";
      retries = 0;
    end else if (phase == "wait") begin
      if (lk) begin
        phase = "por";
        left  = POR_CYCLES;
      end
    end else if (phase == "por") begin
      left--;
      if (left == 0) begin
        phase = "ddr";
        left  = INIT_TIMEOUT;
      end
    end else if (phase == "ddr") begin
      if (in) begin
        phase = "hw";
        left  = HW_CYCLES;
      end else begin
        left--;
        if (left == 0) begin
          if (retries < MAX_RETRY) begin
            retries++;
            phase = "pulse";
            left  = DDR_PULSE;
          end else begin
            phase = "fail";
          end
        end
      end
    end else if (phase == "pulse") begin
      left--;
      if (left == 0) begin
        phase = "ddr";
        left  = INIT_TIMEOUT;
      end
    end else if (phase == "hw") begin
      if (SW_RST_REQ) left = HW_CYCLES;
      else begin
        left--;
        if (left == 0) phase = "run";
      end
    end else if (phase == "run") begin
      if (SW_RST_REQ) begin
        phase = "hw";
        left  = HW_CYCLES;
      end
    end
  endtask

  function automatic logic [8:0] dut_outs();
    return {POR_RSTN, DDR3_RSTN, HW_RSTN, SEQ_DONE, INIT_FAIL, RETRY_CNT};
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check_eq("outs", 32'(dut_outs()), 32'(model_outs()));
  endtask

  task automatic assert_reset();
    #2;
    RSTN    = 1'b0;
    rst_low = 1'b1;
    phase   = "wait";
    retries = 0;
    lock_q  = 2'b00;
    init_q  = 2'b00;
    #1;
    check_eq("async_rst", 32'(dut_outs()), 32'd0);
  endtask

  task automatic release_reset();
    RSTN     = 1'b1;
    rst_low  = 1'b0;
    rst_hold = 2;
  endtask

  int count;

  initial begin
    RSTN       = 1'b1;
    PLL_LOCK   = 1'b0;
    DDR3_INIT  = 1'b0;
    SW_RST_REQ = 1'b0;
    #1;
    RSTN = 1'b0;
    #1;
    check_eq("reset_vals", 32'(dut_outs()), 32'd0);
    repeat (3) tick();
    release_reset();
    repeat (4) tick();

    // Nominal bring-up: lock to POR release is 2 sync + 1 state + POR_CYCLES.
    PLL_LOCK = 1'b1;
    count = 0;
    do begin tick(); count++; end while (!POR_RSTN && count < 50);
    check_eq("por_latency", count, 2 + 1 + POR_CYCLES);
    check_eq("ddr_with_por", 32'(DDR3_RSTN), 32'd1);
    repeat (4) tick();
    DDR3_INIT = 1'b1;
    count = 0;
    do begin tick(); count++; end while (!HW_RSTN && count < 50);
    check_eq("hw_latency", count, HW_CYCLES + 3);
    check_eq("done_with_hw", 32'(SEQ_DONE), 32'd1);
    check_eq("retry_nominal", 32'(RETRY_CNT), 32'd0);

    // Warm reset: POR/DDR3 stay high, model tracks the HW hold.
    SW_RST_REQ = 1'b1;
    repeat (10) tick();
    check_eq("warm_por", 32'({POR_RSTN, DDR3_RSTN, HW_RSTN}), 32'b110);
    SW_RST_REQ = 1'b0;
    repeat (8) tick();

    // Lock loss in RUN: resets fall three edges later.
    PLL_LOCK  = 1'b0;
    DDR3_INIT = 1'b0;
    count = 0;
    do begin tick(); count++; end while (POR_RSTN && count < 20);
    check_eq("lockloss_latency", count, 3);

    // Relock with no calibration: retries run out, then FAIL.
    PLL_LOCK = 1'b1;
    count = 0;
    do begin tick(); count++; end while (!INIT_FAIL && count < 300);
    check_eq("fail_reached", 32'(INIT_FAIL), 32'd1);
    check_eq("fail_retry", 32'(RETRY_CNT), MAX_RETRY);
    check_eq("fail_hw", 32'({HW_RSTN, DDR3_RSTN, POR_RSTN}), 32'b001);
    repeat (5) tick();

    // RSTN pulse mid-POR: restart takes the full hold again.
    assert_reset();
    release_reset();
    repeat (6) tick();
    assert_reset();
    release_reset();
    count = 0;
    do begin tick(); count++; end while (!POR_RSTN && count < 50);
    check_eq("por_after_rst", count, 2 + 2 + 1 + POR_CYCLES);

    // Random episodes.
    for (int ep = 0; ep < 30; ep++) begin
      int unsigned init_at;
      bit          init_never;
      init_at    = $urandom_range(0, 80);
      init_never = ($urandom_range(0, 3) == 0);
      DDR3_INIT  = 1'b0;
      SW_RST_REQ = 1'b0;
      PLL_LOCK   = 1'b1;
      assert_reset();
      release_reset();
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 149) == 0) PLL_LOCK = 1'b0;
        else if (!PLL_LOCK && $urandom_range(0, 3) == 0) PLL_LOCK = 1'b1;
        DDR3_INIT  = !init_never && (c >= int'(init_at)) && ($urandom_range(0, 15) != 0);
        SW_RST_REQ = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 299) == 0) begin
          assert_reset();
          release_reset();
        end
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
